sinc3_decim_stream: RTL and testbench
=====================================

// Module: sinc3_decim_stream
// PURPOSE
//  Parametrised third-order CIC (sinc3) decimator for a 1-bit sigma-delta modulator stream.
//  Runtime-selectable decimation ratio R = 2^dec_log2; signed, offset-corrected, saturated output.
//  Single clock domain. A valid/ready output replaces a derived word clock, and start-up settling samples are discarded.
//  Sits between the modulator bit input and the downstream sample FIFO/DSP.
// PARAMETERS
//  L_MIN     6      smallest legal dec_log2 (must satisfy 3*L_MIN >= OUT_W)
//  L_MAX     12     largest legal dec_log2
//  ACC_W     37     integrator/comb width; must be >= 3*L_MAX+1; all wrap modulo 2^ACC_W
//  OUT_W     16     signed output word width
//  OFFSET    4500   signed constant subtracted after scaling
//  DISCARD   3      decimated outputs suppressed after reset or ratio change
// PORTS
//  clk_adc    in   1      modulator bit clock; all logic on rising edge
//  rstn_adc   in   1      asynchronous active-low reset
//  data_adc   in   1      modulator bit: 0 -> +0, 1 -> +1 into integrator 1
//  en         in   1      1 = process this cycle; 0 = integrators, counter and pipeline all hold
//  dec_log2   in   4      log2(R); values outside [L_MIN,L_MAX] clamp to the nearest limit
//  out_data   out  OUT_W  signed decimated sample
//  out_valid  out  1      out_data holds an unconsumed sample
//  out_ready  in   1      consumer accepts out_data while out_valid=1
//  overrun    out  1      sticky: a sample was dropped because the holding register was full
//  ovr_clr    in   1      synchronous clear of overrun; a new overrun in the same cycle wins
// BEHAVIOUR
//  Reset: all integrators, comb delays, counter and pipeline = 0; out_data=0; out_valid=0; overrun=0.
//   After reset the discard count = DISCARD. Reset mid-frame aborts the frame; no partial sample is emitted.
//  Integrators (en=1): acc1+=bit; acc2+=acc1; acc3+=acc2. Each uses the old register values (registered chain).
//  Counter cnt: counts 0..R-1 on en=1 cycles, then wraps to 0. tick = en & (cnt==R-1).
//  Comb (on tick edge): c1=acc3-d1, c2=c1-d2, c3=c2-d3. Update d1=acc3, d2=c1, d3=c2. y_raw<=c3.
//   Comb arithmetic is combinational within the tick cycle. All values are mod 2^ACC_W.
//  Scale (edge after the tick): u = y_raw[3L:0], unsigned, 0..R^3 where L = clamped dec_log2.
//   s = u - 2^(3L-1); t = s >>> (3L-OUT_W) (arithmetic shift); v = t - OFFSET.
//   v is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  Latency: the sample is presented with out_valid=1 two edges after the tick edge. It then holds while en=0.
//  Discard: while the discard count is > 0, each scaled sample decrements the count and is not presented.
//  Ratio change: a dec_log2 change (after clamping) is sampled every cycle. On the edge after a change:
//   cnt=0; d1/d2/d3 and y_raw cleared; in-flight sample killed; discard count reloaded to DISCARD.
//   Integrators keep running. An already-presented out_data/out_valid is unaffected.
//  Handshake: the sample transfers on an edge with out_valid & out_ready.
//   out_data is stable while out_valid=1 & !out_ready.
//   A new sample arriving on a transfer edge is loaded, so out_valid stays 1 with no bubble.
//   A new sample arriving while out_valid=1 & !out_ready is dropped, old data is kept, and overrun is set.
//  Only one sample is in flight at a time: R >= 2^L_MIN far exceeds the 2-cycle pipeline.
// TESTING
//  1 Reset, OFFSET=0, L=8, data_adc=0 constant, ready=1 -> 1st valid after the 4th tick edge; out_data=-32768 thereafter.
//  2 L=8, data_adc=1 constant -> u=2^24 saturates; out_data=32767 every 256 cycles; overrun=0.
//  3 L=8, OFFSET=4500, alternating 1,0 -> settled out_data=-4500 exactly; with L=12 -> -4500 every 4096 cycles.
//  4 out_ready=0 for 600 cycles at L=8 -> 1st sample held stable, overrun=1 after next tick.
//    ovr_clr -> 0; ready=1 resumes streaming.
//  5 Change dec_log2 8->6 mid-frame -> no output for the next 3 ticks of R=64; then valid samples spaced 64 cycles apart.
//    dec_log2=15 behaves as 12.
//  6 Assert rstn_adc low mid-frame with out_valid=1 -> out_valid=0 and out_data=0 immediately; restart obeys scenario 1.
//    en=0 pulses stretch the output spacing exactly.

Source files
------------

// File: rtl/sinc3_decim_stream.sv
// Third-order CIC (sinc3) decimator for a 1-bit sigma-delta stream: runtime ratio 2^dec_log2,
// offset-corrected saturated output, settling discard and a single-entry valid/ready holding register.
module sinc3_decim_stream #(
    parameter int unsigned L_MIN   = 6,
    parameter int unsigned L_MAX   = 12,
    parameter int unsigned ACC_W   = 37,
    parameter int unsigned OUT_W   = 16,
    parameter int          OFFSET  = 4500,
    parameter int unsigned DISCARD = 3
) (
    input  logic                    clk_adc,
    input  logic                    rstn_adc,
    input  logic                    data_adc,
    input  logic                    en,
    input  logic [3:0]              dec_log2,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    input  logic                    ovr_clr
);
    localparam int unsigned DC_W = ($clog2(DISCARD + 1) < 1) ? 1 : $clog2(DISCARD + 1);
    localparam int unsigned SC_W = ACC_W + 2;
    localparam logic signed [SC_W-1:0] SAT_HI = SC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SC_W-1:0] SAT_LO = ~SAT_HI;

    logic [ACC_W-1:0]        acc1_q, acc1_d, acc2_q, acc2_d, acc3_q, acc3_d;
    logic [ACC_W-1:0]        d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [ACC_W-1:0]        yraw_q, yraw_d;
    logic                    yvld_q, yvld_d, svld_q, svld_d;
    logic signed [OUT_W-1:0] sdata_q, sdata_d, odata_q, odata_d;
    logic                    ovld_q, ovld_d, ovr_q, ovr_d;
    logic [L_MAX-1:0]        cnt_q, cnt_d;
    logic [DC_W-1:0]         disc_q, disc_d;
    logic [3:0]              l_q;
    logic                    seen_q;

    logic [3:0]              l_c;
    logic [5:0]              sh3_c;
    logic [L_MAX-1:0]        cnt_max_c;
    logic                    chg_c, tick_c, new_c;
    logic [ACC_W-1:0]        c1_c, c2_c, c3_c, mask_c, u_c;
    logic signed [SC_W-1:0]  s_c, t_c, v_c;
    logic signed [OUT_W-1:0] sat_c;

    // Ratio clamp, frame tick, comb differences and output scaling
    always_comb begin
        l_c = dec_log2;
        if (dec_log2 < 4'(L_MIN)) begin
            l_c = 4'(L_MIN);
        end else if (dec_log2 > 4'(L_MAX)) begin
            l_c = 4'(L_MAX);
        end
        sh3_c     = 6'(l_c) * 6'd3;
        cnt_max_c = {L_MAX{1'b1}} >> (4'(L_MAX) - l_c);
        chg_c     = seen_q & (l_c != l_q);
        tick_c    = en & (cnt_q == cnt_max_c) & ~chg_c;
        c1_c      = acc3_q - d1_q;
        c2_c      = c1_c - d2_q;
        c3_c      = c2_c - d3_q;
        mask_c    = ~({ACC_W{1'b1}} << (sh3_c + 6'd1));
        u_c       = yraw_q & mask_c;
        s_c       = {2'b00, u_c} - (SC_W'(1) << (sh3_c - 6'd1));
        t_c       = s_c >>> (sh3_c - 6'(OUT_W));
        v_c       = t_c - SC_W'(OFFSET);
        sat_c     = v_c[OUT_W-1:0];
        if (v_c > SAT_HI) begin
            sat_c = SAT_HI[OUT_W-1:0];
        end else if (v_c < SAT_LO) begin
            sat_c = SAT_LO[OUT_W-1:0];
        end
    end

    // Next state: integrators, counter, pipeline, discard and holding register
    always_comb begin
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        acc3_d  = acc3_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        yraw_d  = yraw_q;
        yvld_d  = yvld_q;
        svld_d  = svld_q;
        sdata_d = sdata_q;
        cnt_d   = cnt_q;
        disc_d  = disc_q;
        odata_d = odata_q;
        ovld_d  = ovld_q;
        ovr_d   = ovr_q & ~ovr_clr;
        new_c   = 1'b0;

        if (en) begin
            acc1_d = acc1_q + ACC_W'(data_adc);
            acc2_d = acc2_q + acc1_q;
            acc3_d = acc3_q + acc2_q;
        end

        if (chg_c) begin
            cnt_d  = '0;
            d1_d   = '0;
            d2_d   = '0;
            d3_d   = '0;
            yraw_d = '0;
            yvld_d = 1'b0;
            svld_d = 1'b0;
            disc_d = DC_W'(DISCARD);
        end else if (en) begin
            cnt_d  = tick_c ? '0 : cnt_q + L_MAX'(1);
            if (tick_c) begin
                d1_d   = acc3_q;
                d2_d   = c1_c;
                d3_d   = c2_c;
                yraw_d = c3_c;
            end
            yvld_d = tick_c;
            svld_d = yvld_q;
            if (yvld_q) begin
                sdata_d = sat_c;
            end
            if (svld_q) begin
                if (disc_q != '0) begin
                    disc_d = disc_q - DC_W'(1);
                end else begin
                    new_c = 1'b1;
                end
            end
        end

        if (ovld_q & out_ready) begin
            ovld_d = 1'b0;
        end
        // A sample finding the register still occupied and not being taken is dropped
        if (new_c) begin
            if (ovld_q & ~out_ready) begin
                ovr_d = 1'b1;
            end else begin
                ovld_d  = 1'b1;
                odata_d = sdata_q;
            end
        end
    end

    always_ff @(posedge clk_adc or negedge rstn_adc) begin
        if (!rstn_adc) begin
            acc1_q  <= '0;
            acc2_q  <= '0;
            acc3_q  <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            yraw_q  <= '0;
            yvld_q  <= 1'b0;
            svld_q  <= 1'b0;
            sdata_q <= '0;
            cnt_q   <= '0;
            disc_q  <= DC_W'(DISCARD);
            odata_q <= '0;
            ovld_q  <= 1'b0;
            ovr_q   <= 1'b0;
            l_q     <= 4'(L_MIN);
            seen_q  <= 1'b0;
        end else begin
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            acc3_q  <= acc3_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            yraw_q  <= yraw_d;
            yvld_q  <= yvld_d;
            svld_q  <= svld_d;
            sdata_q <= sdata_d;
            cnt_q   <= cnt_d;
            disc_q  <= disc_d;
            odata_q <= odata_d;
            ovld_q  <= ovld_d;
            ovr_q   <= ovr_d;
            l_q     <= l_c;
            seen_q  <= 1'b1;
        end
    end

    assign out_data  = odata_q;
    assign out_valid = ovld_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_sinc3_decim_stream.sv
// Bench for sinc3_decim_stream: random stimulus, a kernel-convolution reference model feeding
// an expected-sample queue, and an independent monitor checking outputs every cycle.
module tb_sinc3_decim_stream;
    localparam int OFFSET  = 4500;
    localparam int DISCARD = 3;
    localparam int OUT_W   = 16;

    logic clk = 1'b0, rstn = 1'b0, data = 1'b0, en = 1'b0, ready = 1'b0, ovr_clr = 1'b0;
    logic [3:0] dl = 4'd8;
    logic signed [OUT_W-1:0] out_data;
    logic out_valid, overrun;

    sinc3_decim_stream dut (
        .clk_adc  (clk),
        .rstn_adc (rstn),
        .data_adc (data),
        .en       (en),
        .dec_log2 (dl),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(ready),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit  bits[$];
    int  exp_q[$];
    int  frame_pos, disc, pend_val, pend_left, prev_l;
    bit  pend_act, m_full, m_ovr, l_seen, alt;
    int  n_cmp = 0, n_err = 0, n_xfer = 0;

    function automatic void chk(string nm, longint act, longint exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endfunction

    function automatic int clamp_l(logic [3:0] x);
        if (x < 4'd6) return 6;
        if (x > 4'd12) return 12;
        return int'(x);
    endfunction

    // Impulse response of three cascaded length-r boxcars
    function automatic longint h3(int j, int r);
        longint a, b;
        if (j < 0 || j > 3 * r - 3) return 0;
        if (j >= 2 * r) j = 3 * r - 3 - j;
        a = longint'(j);
        if (j < r) return (a + 1) * (a + 2) / 2;
        b = longint'(j - r);
        return (a + 1) * (a + 2) / 2 - 3 * (b + 1) * (b + 2) / 2;
    endfunction

    function automatic int expected(int m, int r, int l);
        longint y, s, t, v;
        y = 0;
        for (int j = 0; j <= 3 * r - 3; j++) begin
            int i;
            i = m - 3 - j;
            if (i >= 0 && bits[i]) y += h3(j, r);
        end
        s = y - (longint'(1) << (3 * l - 1));
        t = s >>> (3 * l - OUT_W);
        v = t - OFFSET;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return int'(v);
    endfunction

    function automatic void model_reset();
        bits.delete();
        exp_q.delete();
        frame_pos = 0;
        disc      = DISCARD;
        pend_act  = 1'b0;
        pend_left = 0;
        pend_val  = 0;
        m_full    = 1'b0;
        m_ovr     = 1'b0;
        l_seen    = 1'b0;
        prev_l    = 0;
    endfunction

    // Effect of one active clock edge given the inputs driven for it
    function automatic void model_edge();
        int l, r, newv;
        bit chg, xfer, newp;
        l = clamp_l(dl);
        r = 1 << l;
        chg = l_seen && (l != prev_l);
        l_seen = 1'b1;
        prev_l = l;
        xfer = m_full && ready;
        newp = 1'b0;
        newv = 0;
        if (chg) begin
            frame_pos = 0;
            pend_act  = 1'b0;
            disc      = DISCARD;
        end else if (en) begin
            if (pend_act) begin
                pend_left--;
                if (pend_left == 0) begin
                    pend_act = 1'b0;
                    if (disc > 0) disc--;
                    else begin
                        newp = 1'b1;
                        newv = pend_val;
                    end
                end
            end
            if (frame_pos == r - 1) begin
                pend_act  = 1'b1;
                pend_left = 2;
                pend_val  = expected(bits.size(), r, l);
                frame_pos = 0;
            end else begin
                frame_pos++;
            end
        end
        if (en) bits.push_back(data);
        if (xfer) m_full = 1'b0;
        if (ovr_clr) m_ovr = 1'b0;
        if (newp) begin
            if (m_full) m_ovr = 1'b1;
            else begin
                m_full = 1'b1;
                exp_q.push_back(newv);
            end
        end
    endfunction

    task automatic cyc(input bit d, input bit e, input bit r, input logic [3:0] l, input bit oc);
        @(negedge clk);
        #1;
        data = d; en = e; ready = r; dl = l; ovr_clr = oc;
        @(posedge clk);
        model_edge();
    endtask

    task automatic run(input int n, input int mode, input logic [3:0] l, input int en_pct, input int rdy_pct);
        for (int k = 0; k < n; k++) begin
            bit d;
            case (mode)
                0: d = 1'b0;
                1: d = 1'b1;
                2: begin d = alt; alt = ~alt; end
                default: d = 1'($urandom_range(0, 1));
            endcase
            cyc(d, int'($urandom_range(0, 99)) < en_pct, int'($urandom_range(0, 99)) < rdy_pct, l, 1'b0);
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        model_reset();
        repeat (ncyc) @(negedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        model_edge();
    endtask

    // Monitor: sampled between the driver update and the next active edge
    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_overrun", overrun, 0);
        end else begin
            chk("valid", out_valid, m_full);
            chk("overrun", overrun, m_ovr);
            if (out_valid) begin
                chk("queue_depth", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("data", out_data, exp_q[0]);
                    if (ready) begin
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        alt = 1'b1;
        model_reset();
        do_reset(3);
        run(2048, 0, 4'd8, 100, 100);
        run(1536, 1, 4'd8, 100, 100);
        run(1536, 2, 4'd8, 100, 100);
        run(600, 3, 4'd8, 100, 0);
        cyc(1'b0, 1'b1, 1'b0, 4'd8, 1'b1);
        run(1000, 3, 4'd8, 100, 100);
        run(130, 3, 4'd8, 100, 100);
        run(1500, 3, 4'd6, 100, 100);
        run(2000, 3, 4'd6, 100, 70);
        run(24800, 2, 4'd15, 100, 100);
        run(700, 3, 4'd2, 100, 100);
        guard = 0;
        while (!m_full && guard < 2000) begin
            run(1, 3, 4'd6, 100, 0);
            guard++;
        end
        run(37, 3, 4'd6, 100, 0);
        #2;
        chk("pre_reset_valid", out_valid, 1);
        do_reset(2);
        run(2048, 0, 4'd8, 100, 100);
        run(3000, 3, 4'd6, 80, 100);
        run(2000, 3, 4'd8, 60, 80);
        #2;
        chk("drain", exp_q.size(), m_full ? 1 : 0);
        chk("transfer_count_min", n_xfer >= 30, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
